// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the sequential Booth multiplier.
//   - state_t      : FSM state encoding (IDLE / RUN / DONE)
//   - booth_pair_t : radix-2 Booth recoding of the pair {Q[0], q_1}
//   - booth_pair() : helper that forms the recoded pair from the raw bits
// ---------------------------------------------------------------------------
package mult_pkg;

    // FSM states. The encoding is fixed so the control unit and any debug
    // probes can decode the state directly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Booth pair {Q[0], q_1}:
    //   01 -> end of a run of ones   : add the multiplicand
    //   10 -> start of a run of ones : subtract the multiplicand
    //   00 / 11 -> inside a run      : accumulator unchanged
    typedef enum logic [1:0] {
        PAIR_NOP0 = 2'b00,
        PAIR_ADD  = 2'b01,
        PAIR_SUB  = 2'b10,
        PAIR_NOP1 = 2'b11
    } booth_pair_t;

    function automatic booth_pair_t booth_pair(input logic q0, input logic q_1);
        return booth_pair_t'({q0, q_1});
    endfunction

endpackage : mult_pkg

// File: rtl/booth_step.sv
// ---------------------------------------------------------------------------
// booth_step
//   One purely combinational radix-2 Booth iteration: conditional add/sub
//   of the multiplicand into the accumulator followed by an arithmetic
//   shift right of the concatenation {ACC, Q, q_1} by one bit.
//
//   Ports
//     i_acc [WIDTH:0]   current accumulator (WIDTH+1 bits, two's complement)
//     i_q   [WIDTH-1:0] current multiplier / low product register
//     i_q1              current extra bit q_1
//     i_m   [WIDTH:0]   sign-extended multiplicand
//     o_acc [WIDTH:0]   next accumulator
//     o_q   [WIDTH-1:0] next Q
//     o_q1              next q_1
// ---------------------------------------------------------------------------
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        unique case (booth_pair(i_q[0], i_q1))
            PAIR_ADD: w_sum = i_acc + i_m;
            PAIR_SUB: w_sum = i_acc - i_m;
            default:  w_sum = i_acc;
        endcase
    end

    // Arithmetic shift right of {ACC, Q, q_1}: the ACC sign bit is
    // replicated, the ACC LSB drops into Q, and the Q LSB becomes q_1.
    always_comb begin
        o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        o_q1  = i_q[0];
    end

endmodule : booth_step

// File: rtl/booth_multiplier.sv
// ---------------------------------------------------------------------------
// booth_multiplier
//   Sequential signed WIDTH x WIDTH multiplier, radix-2 Booth, one
//   iteration per clock. A start strobe in IDLE captures the operands;
//   WIDTH RUN cycles later the 2*WIDTH-bit product is presented on hi/lo
//   together with a one-cycle done pulse.
//
//   Ports
//     clk    in   system clock, rising edge
//     reset  in   asynchronous active-high reset
//     start  in   begin a multiply (only sampled in IDLE)
//     a      in   [WIDTH-1:0] multiplicand, two's complement
//     b      in   [WIDTH-1:0] multiplier, two's complement
//     hi     out  [WIDTH-1:0] upper half of the signed product (registered)
//     lo     out  [WIDTH-1:0] lower half of the signed product (registered)
//     done   out  one-cycle completion pulse, hi/lo valid in that cycle
//     busy   out  high while in RUN or DONE
//
//   WIDTH must be at least 2 so the iteration counter has a bit to count.
// ---------------------------------------------------------------------------
module booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    // Datapath registers. ACC and M carry one extra bit so that negating
    // the most negative multiplicand cannot overflow.
    state_t           r_state;
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [CW-1:0]    r_count;

    // Output registers
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_busy;

    // Next iteration values from the combinational step
    logic [WIDTH:0]   w_acc_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_q1_next;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_booth_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_q1  (r_q1),
        .i_m   (r_m),
        .o_acc (w_acc_next),
        .o_q   (w_q_next),
        .o_q1  (w_q1_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= {a[WIDTH-1], a};
                        r_acc   <= '0;
                        r_q     <= b;
                        r_q1    <= 1'b0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_q     <= w_q_next;
                    r_q1    <= w_q1_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST_ITER) begin
                        // Final iteration: publish the product straight from
                        // the step outputs so hi/lo appear together with done
                        // and never show partial results.
                        r_hi    <= w_acc_next[WIDTH-1:0];
                        r_lo    <= w_q_next;
                        r_done  <= 1'b1;
                        r_count <= '0;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here; the next
                    // operation can only be accepted once back in IDLE.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;
    assign busy = r_busy;

endmodule : booth_multiplier

// File: tb/tb_booth_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier
//   Directed vectors with literal expected products, plus a cycle-level
//   reference model (signed arithmetic and a cycle counter) compared with
//   the DUT outputs after every rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_booth_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: m_phase counts cycles since an accepted start
    // (0 = idle). busy for phases 1..33, done in phase 33, where the
    // exact signed product becomes visible and is then held.
    // ------------------------------------------------------------------
    int           m_phase = 0;
    longint       m_prod  = 0;
    logic [W-1:0] m_hi    = '0;
    logic [W-1:0] m_lo    = '0;

    always @(posedge clk) begin
        longint sa;
        longint sb;
        if (reset) begin
            m_phase = 0;
            m_hi    = '0;
            m_lo    = '0;
        end else if (m_phase == 0) begin
            if (start) begin
                sa      = longint'($signed(a));
                sb      = longint'($signed(b));
                m_prod  = sa * sb;
                m_phase = 1;
            end
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == W + 1) begin
                m_hi = m_prod[63:32];
                m_lo = m_prod[31:0];
            end else if (m_phase == W + 2) begin
                m_phase = 0;
            end
        end
        #1;
        checks++;
        if (busy !== (m_phase >= 1 && m_phase <= W + 1)) begin
            errors++;
            $display("FAIL model_busy t=%0t got=%b want=%b", $time, busy, (m_phase >= 1 && m_phase <= W + 1));
        end
        checks++;
        if (done !== (m_phase == W + 1)) begin
            errors++;
            $display("FAIL model_done t=%0t got=%b want=%b", $time, done, (m_phase == W + 1));
        end
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL model_hilo t=%0t got=%h_%h want=%h_%h", $time, hi, lo, m_hi, m_lo);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Issue one multiply and follow it to completion.
    //   inject_at : busy-cycle number at which a second start (9x9) is
    //               pulsed, 0 for none
    //   poke_done : also pulse start (1x1) during the done cycle
    task automatic run_op(input string name, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic [W-1:0] want_hi, input logic [W-1:0] want_lo,
                          input int inject_at, input bit poke_done);
        int n;
        int dones;
        logic [W-1:0] got_hi;
        logic [W-1:0] got_lo;
        n      = 0;
        dones  = 0;
        got_hi = 'x;
        got_lo = 'x;
        @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        while (busy && n < 100) begin
            n++;
            if (done) begin
                dones++;
                got_hi = hi;
                got_lo = lo;
                if (poke_done) begin
                    start = 1'b1;
                    a     = 32'd1;
                    b     = 32'd1;
                end
            end
            if (n == inject_at) begin
                start = 1'b1;
                a     = 32'd9;
                b     = 32'd9;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(W + 1));
        check({name, "_done_pulses"}, 64'(dones), 64'd1);
        check({name, "_product"}, {got_hi, got_lo}, {want_hi, want_lo});
        @(negedge clk);
        check({name, "_idle_after"}, {63'd0, busy}, 64'd0);
        check({name, "_hold"}, {hi, lo}, {want_hi, want_lo});
        $display("op %s a=%h b=%h hi=%h lo=%h busy_cycles=%0d dones=%0d", name, op_a, op_b, got_hi, got_lo, n, dones);
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {hi, lo}, 64'd0);
        check("reset_flags", {62'd0, done, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("3x4",     32'd3,        32'd4,        32'h00000000, 32'h0000000C, 0, 1'b0);
        run_op("m7x5",    32'hFFFFFFF9, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFDD, 0, 1'b0);
        run_op("minsq",   32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 1'b0);
        run_op("m1xm1",   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 1'b0);
        run_op("busy_st", 32'd2,        32'd3,        32'h00000000, 32'h00000006, 10, 1'b0);
        run_op("st_done", 32'h7FFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000002, 0, 1'b1);

        // Reset in the middle of 5x5: outputs clear without a clock edge
        // and the aborted operation never signals done.
        @(negedge clk);
        start = 1'b1;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_hilo", {hi, lo}, 64'd0);
        check("async_reset_flags", {62'd0, done, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("aborted_no_done", 64'(dones), 64'd0);
        $display("op reset_abort a=00000005 b=00000005 dones=%0d", dones);

        run_op("6x7", 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule : tb_booth_multiplier

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential signed 32×32 multiplier for the multicycle CPU datapath, driving the mult/div result muxes that feed the HI and LO registers. Uses radix-2 Booth recoding, one iteration per clock. The control unit starts it with a one-cycle start strobe and waits for a one-cycle done pulse. It then loads the 64-bit product into HI/LO for `mult`.

## Interface
- WIDTH, 32, operand width; the product is 2×WIDTH, split into hi/lo.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the idle state and clears all outputs.
- start  in  1  begin a multiply; sampled only in IDLE.
- a  in  WIDTH  multiplicand, two's complement; captured when start is accepted.
- b  in  WIDTH  multiplier, two's complement; captured when start is accepted.
- hi  out  WIDTH  upper half of the signed product.
- lo  out  WIDTH  lower half of the signed product.
- done  out  1  one-cycle pulse; hi/lo are valid in the same cycle.
- busy  out  1  high while an operation is in progress (RUN or DONE).

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - With start=1 at the edge: load the multiplicand register M ← a, sign-extended to WIDTH+1.
  - Clear the accumulator ACC (WIDTH+1 bits).
  - Load Q ← b and clear q_1 ← 0.
  - Clear the count ← 0 and go to RUN.
- RUN, each edge, from the Booth pair {Q[0], q_1}:
  - 01: ACC ← ACC + M.
  - 10: ACC ← ACC − M.
  - 00 and 11: no change to ACC.
- RUN, same edge, after the add/subtract:
  - Arithmetic shift right of {ACC, Q, q_1} by one, replicating the ACC MSB.
  - count ← count + 1.
- When count reaches WIDTH−1 on an edge, that is the final iteration; the next state is DONE.
- Accumulator width:
  - ACC is WIDTH+1 bits, so M = −2^(WIDTH−1) and its negation do not overflow.
  - hi takes ACC[WIDTH−1:0]; lo takes Q.
- DONE:
  - done=1 for exactly one cycle; hi/lo hold the final product.
  - The next state is IDLE unconditionally.
- Output holding:
  - hi/lo are registered outputs.
  - They update only on the transition into DONE and hold their values until the next operation completes.
  - They do not show intermediate values during RUN.
- start while busy=1 is ignored; there is no queuing.
- The product is the exact signed 2×WIDTH result, so no overflow flag is generated.

## Timing
- Reset values: state=IDLE, hi=0, lo=0, done=0, busy=0, count=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset during RUN or DONE:
  - The operation is aborted and no done pulse is emitted.
  - hi/lo return to 0.
- Handshake:
  - start is accepted at edge E0.
  - busy=1 from the cycle after E0.
  - The WIDTH RUN iterations occupy edges E1..E_WIDTH.
  - done=1 in the cycle after E_WIDTH. For WIDTH=32, done is high during the cycle following the 32nd edge after E0 (E32); the transition from RUN to DONE occurs at E32.
  - busy falls together with done at edge E_WIDTH+1.
- Back-to-back: a start asserted in the DONE cycle is ignored. The earliest acceptable start is in the first cycle after IDLE is re-entered.
- Operands a/b may change freely after E0.
- done and busy are registered; they are not combinational from start.

## Structure
- A shared package/header `mult_pkg` holds:
  - the state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the Booth pair codes.
- Natural sub-module `booth_step`, purely combinational:
  - inputs {ACC, Q, q_1, M};
  - output is the next {ACC, Q, q_1} after add/subtract and the arithmetic shift.
- The parent holds the FSM, the counter and the output registers.
- The iteration counter is $clog2(WIDTH) bits wide and wraps only under FSM control.

## Test plan
- 3 × 4: start with a=3, b=4 → after the latency above, done=1 with hi=0x00000000, lo=0x0000000C. busy is high for exactly 33 cycles.
- −7 × 5: a=0xFFFFFFF9, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFDD.
- Most-negative squared: a=b=0x80000000 → hi=0x40000000, lo=0x00000000. This checks the WIDTH+1 accumulator.
- −1 × −1: a=b=0xFFFFFFFF → hi=0, lo=1.
- Start while busy: issue 2×3, then pulse start with a=9, b=9 at cycle 10 → exactly one done pulse, with hi=0 and lo=6.
- Reset mid-operation: start 5×5, assert reset at cycle 15, release it, then start 6×7 → no done pulse for 5×5, hi=lo=0 immediately on reset. The later operation returns lo=42, hi=0 with normal latency.
